sqwave_meas: RTL and testbench

SQWAVE_MEAS -- requirements
Module: sqwave_meas

---
 rtl/sqwave_pkg.sv | 13 +
 rtl/sync_edge.sv | 20 ++
 rtl/sqwave_meas.sv | 107 ++++++++++
 tb/tb_sqwave_meas.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sqwave_pkg.sv
// sqwave_pkg: shared FSM state encoding and default sizing for the square-wave
// measurement block and its companion generator.
package sqwave_pkg;
    localparam int TICK_CYCLES_DEF = 5;
    localparam int UNIT_W_DEF      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        STUCK = 2'd3
    } state_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchronizer for an asynchronous input, plus single-cycle
// rise/fall pulses found by comparing the synchronized level with its last value.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic meta, prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {meta, level, prev} <= 3'b000;
        else        {meta, level, prev} <= {in, meta, level};
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;
endmodule

// File: rtl/sqwave_meas.sv
// sqwave_meas: measures high/low times of a square wave in units of TICK_CYCLES
// clocks, with rounding, and flags a level held beyond the measurable range.
module sqwave_meas
    import sqwave_pkg::*;
#(
    parameter int TICK_CYCLES = TICK_CYCLES_DEF,
    parameter int UNIT_W      = UNIT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in,
    output logic [UNIT_W-1:0] m,
    output logic [UNIT_W-1:0] n,
    output logic              valid,
    output logic              stuck
);
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0]     PRE_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [PW-1:0]     PRE_HALF = PW'(TICK_CYCLES / 2);
    localparam logic [UNIT_W-1:0] MAX      = '1;

    logic level, rise, fall, toggle, wrap, ovf, valid_d, stuck_d;
    logic [PW-1:0] pre;
    logic [UNIT_W-1:0] cnt, meas, m_tmp, m_tmp_d, m_d, n_d;
    state_t state, state_d;

    sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign toggle = rise | fall;
    assign wrap   = (pre == PRE_LAST);
    assign ovf    = wrap && (cnt == MAX) && !toggle;
    // The edge cycle itself still counts toward the phase just ended.
    assign meas   = (wrap && cnt != MAX) ? cnt + UNIT_W'(1) : cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            cnt <= '0;
        end else if (toggle) begin
            pre <= PRE_HALF;
            cnt <= '0;
        end else begin
            pre <= wrap ? '0 : pre + PW'(1);
            cnt <= wrap ? cnt + UNIT_W'(1) : cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            m_tmp <= '0;
            m     <= '0;
            n     <= '0;
            valid <= 1'b0;
            stuck <= 1'b0;
        end else begin
            state <= state_d;
            m_tmp <= m_tmp_d;
            m     <= m_d;
            n     <= n_d;
            valid <= valid_d;
            stuck <= stuck_d;
        end
    end

    always_comb begin
        state_d = state;
        m_tmp_d = m_tmp;
        m_d     = m;
        n_d     = n;
        valid_d = 1'b0;
        stuck_d = stuck;
        if (state != STUCK && ovf) begin
            state_d = STUCK;
            m_d     = level ? MAX : '0;
            n_d     = level ? '0 : MAX;
            valid_d = 1'b1;
            stuck_d = 1'b1;
        end else begin
            case (state)
                IDLE: state_d = rise ? HIGH : IDLE;
                HIGH: if (fall) begin
                    state_d = LOW;
                    m_tmp_d = meas;
                end
                LOW: if (rise) begin
                    state_d = HIGH;
                    m_d     = m_tmp;
                    n_d     = meas;
                    valid_d = 1'b1;
                end
                STUCK: if (toggle) begin
                    state_d = rise ? HIGH : IDLE;
                    stuck_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sqwave_meas.sv
// tb_sqwave_meas: cycle-by-cycle comparison against a phase-length model, plus
// a table of phase patterns and hand sequences for stuck, latency and reset.
module tb_sqwave_meas;
    import sqwave_pkg::*;

    localparam int T    = 5;
    localparam int W    = 4;
    localparam int MAXU = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in = 1'b0;
    logic [W-1:0] m, n;
    logic valid, stuck;

    sqwave_meas #(.TICK_CYCLES(T), .UNIT_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .m     (m),
        .n     (n),
        .valid (valid),
        .stuck (stuck)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { int m; int n; } pair_t;
    typedef struct { int hi; int lo; int m; int n; } vec_t;
    pair_t cap[$];
    vec_t tbl[12];

    // Model: samples seen by the synchronizer, current phase length and bookkeeping.
    logic x1, x2, x3;
    int ph, ofs, hi;
    bit trk, st_m, ev, est, prev_valid;
    int em, en;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        {x1, x2, x3} = 3'b000;
        ph = 0; ofs = 0; hi = -1;
        trk = 0; st_m = 0; ev = 0; est = 0; prev_valid = 0;
        em = 0; en = 0;
    endtask

    // One clock edge: the synchronized level lags the sampled input by two edges,
    // a phase of D cycles measures (D + T/2) / T units, and a level lasting long
    // enough to exceed the unit range enters the stuck condition.
    task automatic model_edge(input logic x);
        logic s2, s3, r, f;
        int u;
        bit ovf;
        s2 = x2; s3 = x3;
        r = s2 && !s3;
        f = !s2 && s3;
        ph++;
        u = (ofs + ph) / T;
        ovf = !(r || f) && u > MAXU;
        if (u > MAXU) u = MAXU;
        ev = 0;
        if (!st_m && ovf) begin
            st_m = 1; est = 1; ev = 1;
            em = s2 ? MAXU : 0;
            en = s2 ? 0 : MAXU;
            trk = 0; hi = -1;
        end else if (st_m) begin
            if (r || f) begin
                st_m = 0; est = 0; trk = r; hi = -1;
            end
        end else if (r) begin
            if (trk && hi >= 0) begin
                ev = 1; em = hi; en = u;
            end
            trk = 1; hi = -1;
        end else if (f && trk) begin
            hi = u;
        end
        if (r || f) begin
            ph = 0; ofs = T / 2;
        end
        x3 = x2; x2 = x1; x1 = x;
    endtask

    task automatic step(input logic x);
        in = x;
        @(posedge clk);
        model_edge(x);
        #1;
        if (valid) cap.push_back('{int'(m), int'(n)});
        check("valid", int'(valid), int'(ev));
        check("m", int'(m), em);
        check("n", int'(n), en);
        check("stuck", int'(stuck), int'(est));
        check("valid_gap", int'(valid && prev_valid), 0);
        prev_valid = valid;
        @(negedge clk);
    endtask

    task automatic phase(input logic lvl, input int cyc);
        repeat (cyc) step(lvl);
    endtask

    task automatic gen(input int mu, input int nu, input int periods);
        repeat (periods) begin
            phase(1'b1, mu * T);
            phase(1'b0, nu * T);
        end
    endtask

    task automatic check_cap(input string name, input int from, input int cnt, input int m_e, input int n_e);
        check({name, "_count"}, cap.size(), cnt);
        for (int i = from; i < cap.size(); i++) begin
            check($sformatf("%s_m[%0d]", name, i), cap[i].m, m_e);
            check($sformatf("%s_n[%0d]", name, i), cap[i].n, n_e);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_m"}, int'(m), 0);
        check({name, "_n"}, int'(n), 0);
        check({name, "_valid"}, int'(valid), 0);
        check({name, "_stuck"}, int'(stuck), 0);
    endtask

    initial begin
        int lat;
        logic lv;
        tbl[0]  = '{5, 10, 1, 2};
        tbl[1]  = '{14, 10, 3, 2};
        tbl[2]  = '{15, 10, 3, 2};
        tbl[3]  = '{17, 10, 3, 2};
        tbl[4]  = '{13, 10, 3, 2};
        tbl[5]  = '{12, 12, 2, 2};
        tbl[6]  = '{18, 8, 4, 2};
        tbl[7]  = '{3, 3, 1, 1};
        tbl[8]  = '{2, 2, 0, 0};
        tbl[9]  = '{7, 8, 1, 2};
        tbl[10] = '{77, 5, 15, 1};
        tbl[11] = '{30, 77, 6, 15};

        model_reset();
        @(negedge clk);
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Phase table: the valid for entry i appears at the rise that opens entry i+1.
        phase(1'b0, 5);
        cap.delete();
        foreach (tbl[i]) begin
            phase(1'b1, tbl[i].hi);
            phase(1'b0, tbl[i].lo);
        end
        phase(1'b1, 5);
        check("tbl_count", cap.size(), 12);
        for (int i = 0; i < 12 && i < cap.size(); i++) begin
            check($sformatf("tbl_m[%0d]", i), cap[i].m, tbl[i].m);
            check($sformatf("tbl_n[%0d]", i), cap[i].n, tbl[i].n);
        end

        // Latency: valid is registered on the third edge counting the sampling edge.
        phase(1'b0, 10);
        lat = 0;
        do begin
            step(1'b1);
            lat++;
        end while (!valid && lat < 10);
        check("latency", lat, 3);

        phase(1'b0, 10);
        cap.delete();
        gen(1, 2, 6);
        check_cap("gen12", 1, 6, 1, 2);
        cap.delete();
        gen(3, 2, 5);
        check_cap("gen32", 1, 5, 3, 2);

        cap.delete();
        phase(1'b0, 100);
        check_cap("stuck_low", 0, 1, 0, MAXU);
        check("stuck_low_flag", int'(stuck), 1);
        phase(1'b1, 10);
        check("stuck_low_exit", int'(stuck), 0);

        cap.delete();
        phase(1'b1, 100);
        check_cap("stuck_high", 0, 1, MAXU, 0);
        check("stuck_high_flag", int'(stuck), 1);
        cap.delete();
        phase(1'b0, 10);
        phase(1'b1, 10);
        phase(1'b0, 10);
        check("after_idle_none", cap.size(), 0);
        phase(1'b1, 5);
        check_cap("after_idle", 0, 1, 2, 2);

        // Reset in the middle of a high phase.
        phase(1'b0, 10);
        phase(1'b1, 4);
        #5 rst_n = 1'b0;
        #1 check_zero("mid_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cap.delete();
        phase(1'b1, 8);
        phase(1'b0, 10);
        check("post_reset_none", cap.size(), 0);
        phase(1'b1, 5);
        check_cap("post_reset", 0, 1, 2, 2);

        lv = 1'b0;
        for (int i = 0; i < 160; i++) begin
            lv = ~lv;
            phase(lv, ($urandom_range(0, 9) == 0) ? $urandom_range(60, 100) : $urandom_range(1, 30));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
